// File: rtl/eth_pkg.sv
// Ethernet constants and receive-FSM state encoding shared by the TX preamble
// inserter and the RX preamble stripper.
package eth_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'h5d;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        DATA,
        PASS,
        DROP
    } state_t;

endpackage

// File: rtl/rx_preamble_strip.sv
// Strips the 0x55 preamble and 0x5d SFD from received packets, forwarding only
// frame bytes; malformed preambles drop the packet with a one-ce error pulse.
module rx_preamble_strip
    import eth_pkg::*;
#(
    parameter int unsigned MIN_PREAMBLE = 4,
    parameter int unsigned MAX_PREAMBLE = 7
) (
    input  logic       i_clk,
    input  logic       i_areset_n,
    input  logic       i_ce,
    input  logic       i_en,
    input  logic       i_v,
    input  logic [7:0] i_d,
    output logic       o_v,
    output logic [7:0] o_d,
    output logic       o_err
);

    localparam logic [3:0] MIN_CNT = 4'(MIN_PREAMBLE);
    localparam logic [3:0] MAX_CNT = 4'(MAX_PREAMBLE);

    state_t     state_p1, state_p0;
    logic [3:0] cnt_p1, cnt_p0;
    logic       vld_p0;
    logic       err_p0;

    logic is_pre;
    logic sfd_ok;
    assign is_pre = (i_d == PREAMBLE_BYTE);
    assign sfd_ok = (i_d == SFD_BYTE) && (cnt_p1 >= MIN_CNT);

    // Stage p1: state, counter and output registers, advancing only on ce
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_p1 <= DROP;
            cnt_p1   <= '0;
            o_v      <= 1'b0;
            o_d      <= '0;
            o_err    <= 1'b0;
        end else if (i_ce) begin
            state_p1 <= state_p0;
            cnt_p1   <= cnt_p0;
            o_v      <= vld_p0;
            o_d      <= vld_p0 ? i_d : 8'h00;
            o_err    <= err_p0;
        end
    end

    // Stage p0: next-state decode
    always_comb begin
        state_p0 = state_p1;
        cnt_p0   = cnt_p1;
        case (state_p1)
            IDLE: begin
                if (i_v) begin
                    if (!i_en) begin
                        state_p0 = PASS;
                    end else if (is_pre) begin
                        state_p0 = HUNT;
                        cnt_p0   = 4'd1;
                    end else begin
                        state_p0 = DROP;
                    end
                end
            end
            HUNT: begin
                if (!i_v) begin
                    state_p0 = IDLE;
                end else if (is_pre) begin
                    if (cnt_p1 < MAX_CNT) cnt_p0 = cnt_p1 + 4'd1;
                    else                  state_p0 = DROP;
                end else if (sfd_ok) begin
                    state_p0 = DATA;
                end else begin
                    state_p0 = DROP;
                end
            end
            DATA, PASS, DROP: begin
                if (!i_v) state_p0 = IDLE;
            end
            default: state_p0 = DROP;
        endcase
    end

    // Stage p0: forward/error decode
    always_comb begin
        vld_p0 = 1'b0;
        err_p0 = 1'b0;
        case (state_p1)
            IDLE: begin
                if (i_v) begin
                    if (!i_en)        vld_p0 = 1'b1;
                    else if (!is_pre) err_p0 = 1'b1;
                end
            end
            HUNT: begin
                if (!i_v)        err_p0 = 1'b1;
                else if (is_pre) err_p0 = !(cnt_p1 < MAX_CNT);
                else             err_p0 = !sfd_ok;
            end
            DATA, PASS: vld_p0 = i_v;
            default: begin
                vld_p0 = 1'b0;
                err_p0 = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rx_preamble_strip.sv
// Directed-vector bench for rx_preamble_strip with hand-computed expectations.
module tb_rx_preamble_strip;

    logic       i_clk = 1'b0;
    logic       i_areset_n = 1'b1;
    logic       i_ce = 1'b0;
    logic       i_en = 1'b1;
    logic       i_v = 1'b0;
    logic [7:0] i_d = 8'h00;
    logic       o_v;
    logic [7:0] o_d;
    logic       o_err;

    int errors = 0;
    int checks = 0;

    logic       obs_v;
    logic [7:0] obs_d;
    logic       obs_err;

    rx_preamble_strip #(.MIN_PREAMBLE(4), .MAX_PREAMBLE(7)) dut (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_ce       (i_ce),
        .i_en       (i_en),
        .i_v        (i_v),
        .i_d        (i_d),
        .o_v        (o_v),
        .o_d        (o_d),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic step(input logic ce, input logic v, input logic [7:0] d);
        i_ce = ce;
        i_v  = v;
        i_d  = d;
        @(posedge i_clk);
        #1;
        obs_v   = o_v;
        obs_d   = o_d;
        obs_err = o_err;
    endtask

    task automatic test_reset;
        #1 i_areset_n = 1'b0;
        #2;
        checks++;
        if ({o_v, o_d, o_err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h err=%b, want v=0 d=00 err=0", o_v, o_d, o_err);
        end
        @(posedge i_clk);
        #2 i_areset_n = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if ({obs_v, obs_d, obs_err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_release: got v=%b d=%h err=%b, want v=0 d=00 err=0", obs_v, obs_d, obs_err);
        end
    endtask

    task automatic test_long_frame;
        int vcount = 0;
        i_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, (i < 7) ? 8'h55 : 8'h5d);
            checks++;
            if ({obs_v, obs_d, obs_err} !== 10'b0) begin
                errors++;
                $display("FAIL long_preamble[%0d]: got v=%b d=%h err=%b, want v=0 d=00 err=0", i, obs_v, obs_d, obs_err);
            end
        end
        for (int i = 1; i <= 64; i++) begin
            step(1'b1, 1'b1, 8'(i));
            if (obs_v === 1'b1) vcount++;
            checks++;
            if ({obs_v, obs_d, obs_err} !== {1'b1, 8'(i), 1'b0}) begin
                errors++;
                $display("FAIL long_data[%0d]: got v=%b d=%h err=%b, want v=1 d=%h err=0", i, obs_v, obs_d, obs_err, 8'(i));
            end
        end
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if ({obs_v, obs_d, obs_err} !== 10'b0) begin
            errors++;
            $display("FAIL long_end: got v=%b d=%h err=%b, want v=0 d=00 err=0", obs_v, obs_d, obs_err);
        end
        checks++;
        if (vcount != 64) begin
            errors++;
            $display("FAIL long_count: got %0d valid bytes, want 64", vcount);
        end
    endtask

    task automatic test_short_preamble;
        logic [7:0] good [7] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h5d, 8'hA1, 8'hA2};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h55);
            checks++;
            if ({obs_v, obs_err} !== 2'b00) begin
                errors++;
                $display("FAIL short_pre[%0d]: got v=%b err=%b, want v=0 err=0", i, obs_v, obs_err);
            end
        end
        step(1'b1, 1'b1, 8'h5d);
        checks++;
        if ({obs_v, obs_d, obs_err} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL short_sfd_err: got v=%b d=%h err=%b, want v=0 d=00 err=1", obs_v, obs_d, obs_err);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 8'(8'h10 + i));
            checks++;
            if ({obs_v, obs_d, obs_err} !== 10'b0) begin
                errors++;
                $display("FAIL short_drop[%0d]: got v=%b d=%h err=%b, want v=0 d=00 err=0", i, obs_v, obs_d, obs_err);
            end
        end
        step(1'b1, 1'b0, 8'h00);
        // Exactly MIN_PREAMBLE preamble bytes must be accepted
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, good[i]);
            checks++;
            if ({obs_v, obs_d, obs_err} !== ((i >= 5) ? {1'b1, good[i], 1'b0} : 10'b0)) begin
                errors++;
                $display("FAIL short_next[%0d]: got v=%b d=%h err=%b, want v=%b d=%h err=0",
                         i, obs_v, obs_d, obs_err, (i >= 5), (i >= 5) ? good[i] : 8'h00);
            end
        end
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_long_preamble;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 8'h55);
            checks++;
            if ({obs_v, obs_err} !== {1'b0, (i == 7)}) begin
                errors++;
                $display("FAIL over_pre[%0d]: got v=%b err=%b, want v=0 err=%b", i, obs_v, obs_err, (i == 7));
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 0) ? 8'h5d : 8'(8'h20 + i));
            checks++;
            if ({obs_v, obs_d, obs_err} !== 10'b0) begin
                errors++;
                $display("FAIL over_drop[%0d]: got v=%b d=%h err=%b, want v=0 d=00 err=0", i, obs_v, obs_d, obs_err);
            end
        end
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_passthrough;
        logic [7:0] raw [4] = '{8'h55, 8'h55, 8'h5d, 8'hAA};
        i_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, raw[i]);
            if (i == 0) i_en = 1'b1;
            checks++;
            if ({obs_v, obs_d, obs_err} !== {1'b1, raw[i], 1'b0}) begin
                errors++;
                $display("FAIL pass[%0d]: got v=%b d=%h err=%b, want v=1 d=%h err=0", i, obs_v, obs_d, obs_err, raw[i]);
            end
        end
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if ({obs_v, obs_d, obs_err} !== 10'b0) begin
            errors++;
            $display("FAIL pass_end: got v=%b d=%h err=%b, want v=0 d=00 err=0", obs_v, obs_d, obs_err);
        end
    endtask

    task automatic test_ce_gating;
        logic [7:0] pk  [8] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h5d, 8'h11, 8'h22, 8'h33};
        logic [7:0] bad [3] = '{8'h55, 8'h55, 8'h00};
        logic       ev;
        logic [7:0] ed;
        logic       ee;
        for (int i = 0; i < 9; i++) begin
            ev = (i >= 5) && (i < 8);
            ed = ev ? pk[i] : 8'h00;
            step(1'b1, (i < 8), (i < 8) ? pk[i] : 8'h00);
            for (int g = 0; g < 4; g++) begin
                if (g > 0) step(1'b0, (i < 8), (i < 8) ? pk[i] : 8'h00);
                checks++;
                if ({obs_v, obs_d, obs_err} !== {ev, ed, 1'b0}) begin
                    errors++;
                    $display("FAIL ce_data[%0d.%0d]: got v=%b d=%h err=%b, want v=%b d=%h err=0",
                             i, g, obs_v, obs_d, obs_err, ev, ed);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            ee = (i == 2);
            step(1'b1, (i < 3), (i < 3) ? bad[i] : 8'h00);
            for (int g = 0; g < 4; g++) begin
                if (g > 0) step(1'b0, (i < 3), (i < 3) ? bad[i] : 8'h00);
                checks++;
                if ({obs_v, obs_d, obs_err} !== {1'b0, 8'h00, ee}) begin
                    errors++;
                    $display("FAIL ce_err[%0d.%0d]: got v=%b d=%h err=%b, want v=0 d=00 err=%b",
                             i, g, obs_v, obs_d, obs_err, ee);
                end
            end
        end
    endtask

    task automatic test_reset_mid_data;
        logic [7:0] pk [7] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h5d, 8'h31, 8'h32};
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, pk[i]);
        checks++;
        if ({obs_v, obs_d} !== {1'b1, 8'h32}) begin
            errors++;
            $display("FAIL rst_pre: got v=%b d=%h, want v=1 d=32", obs_v, obs_d);
        end
        i_d = 8'h33;
        #2 i_areset_n = 1'b0;
        #1;
        checks++;
        if ({o_v, o_d, o_err} !== 10'b0) begin
            errors++;
            $display("FAIL rst_async: got v=%b d=%h err=%b, want v=0 d=00 err=0", o_v, o_d, o_err);
        end
        @(posedge i_clk);
        #2 i_areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'(8'h34 + i));
            checks++;
            if ({obs_v, obs_d, obs_err} !== 10'b0) begin
                errors++;
                $display("FAIL rst_discard[%0d]: got v=%b d=%h err=%b, want v=0 d=00 err=0", i, obs_v, obs_d, obs_err);
            end
        end
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if ({obs_v, obs_err} !== 2'b00) begin
            errors++;
            $display("FAIL rst_idle: got v=%b err=%b, want v=0 err=0", obs_v, obs_err);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, (i < 4) ? 8'h55 : ((i == 4) ? 8'h5d : 8'h41));
        checks++;
        if ({obs_v, obs_d, obs_err} !== {1'b1, 8'h41, 1'b0}) begin
            errors++;
            $display("FAIL rst_next: got v=%b d=%h err=%b, want v=1 d=41 err=0", obs_v, obs_d, obs_err);
        end
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_runt;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if ({obs_v, obs_d, obs_err} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL runt_err: got v=%b d=%h err=%b, want v=0 d=00 err=1", obs_v, obs_d, obs_err);
        end
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if (obs_err !== 1'b0) begin
            errors++;
            $display("FAIL runt_clear: got err=%b, want err=0", obs_err);
        end
    endtask

    initial begin
        test_reset();
        test_long_frame();
        test_short_preamble();
        test_long_preamble();
        test_passthrough();
        test_ce_gating();
        test_runt();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_preamble_strip.md
# rx_preamble_strip

Receive-side counterpart of the transmit preamble inserter. It sits between the RMII/MII byte assembler and the receive CRC checker. It hunts each incoming packet for the preamble (0x55 bytes) and start-of-frame delimiter (0x5d, same byte orientation the TX path emits), strips them, and forwards only the frame bytes that follow. Malformed preambles drop the whole packet and flag an error pulse; with stripping disabled, packets pass through untouched.

## Interface
- MIN_PREAMBLE, 4: minimum count of 0x55 bytes required before the SFD (1..MAX_PREAMBLE)
- MAX_PREAMBLE, 7: maximum count of 0x55 bytes accepted before the SFD (≤15)
- i_clk  input  1  system clock; all logic on rising edge
- i_areset_n  input  1  asynchronous, active-low reset
- i_ce  input  1  byte-rate clock enable; state and outputs advance only when high
- i_en  input  1  1 = strip preamble, 0 = raw pass-through; sampled at packet start only
- i_v  input  1  input byte valid; high for the whole packet
- i_d  input  8  input data byte
- o_v  output  1  output byte valid
- o_d  output  8  output data byte
- o_err  output  1  one-ce-cycle pulse: packet dropped for bad preamble

## Operation
- States: IDLE, HUNT, DATA, PASS, DROP. 4-bit preamble counter `cnt`.
- IDLE, i_ce && i_v: if !i_en → PASS, forward this byte. Else if i_d==0x55 → HUNT, cnt=1. Else → DROP, o_err.
- HUNT, i_ce:
  - !i_v → IDLE, o_err (runt).
  - i_d==0x55 && cnt<MAX_PREAMBLE → cnt+1.
  - i_d==0x55 && cnt==MAX_PREAMBLE → DROP, o_err.
  - i_d==0x5d && cnt≥MIN_PREAMBLE → DATA. SFD itself is not forwarded.
  - i_d==0x5d && cnt<MIN_PREAMBLE → DROP, o_err.
  - Any other byte → DROP, o_err.
- DATA/PASS, i_ce: i_v → forward i_d; !i_v → IDLE.
- DROP, i_ce: wait for !i_v → IDLE. Nothing is forwarded.
- i_en changes mid-packet are ignored until the next IDLE.
- o_d is 0x00 whenever o_v is low, so the output is deterministic for the bench.
- Counter saturates by construction (never exceeds MAX_PREAMBLE); no wrap.

## Timing
- Reset (asynchronous assert, synchronous release): state=DROP, cnt=0, o_v=0, o_d=0x00, o_err=0. Outputs clear immediately on assertion.
  - Starting in DROP means a packet already in progress at reset release is discarded silently (no o_err). With i_v low, the block reaches IDLE on the first ce.
- Latency: one ce-cycle. A byte accepted at ce edge k appears on o_v/o_d after edge k.
- First o_v after SFD: the cycle after the first post-SFD byte is sampled.
- o_v falls on the ce edge that samples i_v low. There is no trailing garbage byte.
- o_err is high for exactly one ce-cycle: set on the deciding ce edge, cleared on the next ce edge. It is held while i_ce is low.
- Simultaneous events:
  - i_v falling exactly when the SFD would arrive in HUNT → runt error.
  - A new i_v rising on the same ce as DATA→IDLE cannot occur, since one ce of i_v low always separates packets.
- i_ce low: all registers hold, outputs included.

## Structure
- Shared ethernet package:
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'h5d, shared with the TX preamble inserter
  - state enum {IDLE, HUNT, DATA, PASS, DROP}
- Single flat module; no sub-module is warranted.

## Test plan
- i_en=1, 7×0x55, 0x5d, then 0x01..0x40, i_v low → o_v high exactly 64 ce-cycles carrying 0x01..0x40, starting one ce after 0x01 is sampled. o_err never set.
- i_en=1, 3×0x55, 0x5d, 5 bytes (MIN_PREAMBLE=4) → no o_v; one o_err pulse on the 0x5d cycle. The next valid packet is received correctly.
- i_en=1, 8×0x55, 0x5d, data → o_err pulse on the 8th 0x55; no output for the packet.
- i_en=0, packet 0x55,0x55,0x5d,0xAA → all 4 bytes forwarded unchanged, one-cycle latency. Toggling i_en mid-packet does not alter the stream.
- i_ce toggled 1-of-4 during a valid packet → identical byte sequence to the full-rate case; o_v/o_d/o_err held between ce pulses.
- Reset asserted mid-DATA, released with i_v still high → o_v=0 immediately. That packet's remainder is discarded without o_err; the next packet is received intact.
